// File: rtl/uart_rx_buffer_pkg.sv
// Package for the UART receive buffer.
// Holds the data width and default FIFO geometry (taken from uart_defs.vh so
// the TX path sees the same numbers) and the capture-stage record type.
package uart_rx_buffer_pkg;
  `include "uart_defs.vh"

  localparam int DATA_W         = `UART_DATA_W;
  localparam int RX_FIFO_DEPTH  = `UART_RX_FIFO_DEPTH;
  localparam int RX_FIFO_ADDR_W = `UART_RX_FIFO_ADDR_W;

  // One byte sitting between rxReady edge detection and the FIFO write port.
  // valid is only set for bytes that arrived without a framing error.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rx_cap_t;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Interface bundling every non-clock/reset signal of uart_rx_buffer.
//   slave  modport : the buffer (takes receiver/consumer inputs, drives status)
//   master modport : the environment (UART receiver + consumer side)
//
// Strobe semantics: rxReady is a level-or-pulse indication; only its rising
// edge is a write event, and rxData/rxError are sampled in that cycle. rd is a
// request with no backpressure: it is honoured when empty=0 and silently
// ignored when empty=1. A honoured rd produces dataValid=1 for exactly one
// cycle, one cycle later, with data carrying the popped byte; data keeps that
// value until the next pop.
interface uart_rx_buffer_if #(
  parameter int ADDR_W = uart_rx_buffer_pkg::RX_FIFO_ADDR_W
);
  logic                                  rxReady;
  logic [uart_rx_buffer_pkg::DATA_W-1:0] rxData;
  logic                                  rxError;
  logic                                  rd;
  logic                                  clrFlags;
  logic [uart_rx_buffer_pkg::DATA_W-1:0] data;
  logic                                  dataValid;
  logic                                  empty;
  logic                                  full;
  logic [ADDR_W:0]                       count;
  logic                                  overflow;
  logic                                  frameErr;

  modport slave (
    input  rxReady, rxData, rxError, rd, clrFlags,
    output data, dataValid, empty, full, count, overflow, frameErr
  );

  modport master (
    output rxReady, rxData, rxError, rd, clrFlags,
    input  data, dataValid, empty, full, count, overflow, frameErr
  );
endinterface

// File: rtl/uart_defs.vh
// Shared UART definitions used by both the RX and TX paths.
//   UART_DATA_W         : width of one UART character in bits
//   UART_RX_FIFO_DEPTH  : default receive FIFO depth in bytes (power of two)
//   UART_RX_FIFO_ADDR_W : log2 of the default receive FIFO depth
`ifndef UART_DEFS_VH
`define UART_DEFS_VH
`define UART_DATA_W         8
`define UART_RX_FIFO_DEPTH  64
`define UART_RX_FIFO_ADDR_W 6
`endif

// File: rtl/uart_rx_fifo.sv
// Byte FIFO storage for the UART receive buffer.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   i_push         : write i_push_data this edge (already qualified by caller)
//   i_pop          : advance read pointer this edge (already qualified)
//   o_pop_data     : byte at the read pointer (combinational read)
//   o_empty/o_full : registered occupancy flags
//   o_count        : registered number of stored bytes
// The caller guarantees i_push is never set when full without i_pop, and i_pop
// is never set when empty, so this block does no protection of its own.
module uart_rx_fifo
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count
);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  // Array contents are never reset so the storage maps onto RAM.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic [ADDR_W:0]   w_count_next;

  always_comb begin
    w_count_next = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_next = r_count + (ADDR_W + 1)'(1);
      2'b01:   w_count_next = r_count - (ADDR_W + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers are exactly ADDR_W bits, so DEPTH-1 + 1 wraps to 0 by itself.
  // Flags are computed from the next count so they never lag by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (i_push) r_wptr <= r_wptr + ADDR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + ADDR_W'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == FULL_COUNT);
    end
  end

  // When full with push and pop together, wptr == rptr: the read here sees the
  // old (oldest) byte, the new byte lands in that slot at the edge.
  assign o_pop_data = r_mem[r_rptr];
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_count    = r_count;
endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: turns rxReady rising edges into FIFO writes, keeps
// sticky overflow / framing-error flags, and returns bytes to a consumer on rd.
// Ports:
//   clk      : sole clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : uart_rx_buffer_if.slave (rxReady, rxData, rxError, rd,
//              clrFlags in; data, dataValid, empty, full, count, overflow,
//              frameErr out)
// Parameters: DEPTH (power of two, 4..256) and ADDR_W = log2(DEPTH).
//
// Write path: edge detect -> one-cycle capture register -> FIFO write. A byte
// is therefore counted one edge after its rxReady rising edge is sampled.
module uart_rx_buffer #(
  parameter int DEPTH  = uart_rx_buffer_pkg::RX_FIFO_DEPTH,
  parameter int ADDR_W = uart_rx_buffer_pkg::RX_FIFO_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_buffer_if.slave bus
);
  import uart_rx_buffer_pkg::*;

  logic              r_rx_prev;
  rx_cap_t           r_cap;
  logic [DATA_W-1:0] r_data;
  logic              r_data_valid;
  logic              r_overflow;
  logic              r_frame_err;

  logic              w_wr_evt;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_bad_byte;
  logic [DATA_W-1:0] w_pop_data;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W:0]   w_count;

  // r_rx_prev resets to 0, so rxReady already high when reset releases is
  // seen as a fresh rising edge on the first clock.
  assign w_wr_evt   = bus.rxReady & ~r_rx_prev;
  assign w_bad_byte = w_wr_evt & bus.rxError;

  // Pop only when something is stored; a pop frees a slot, so a full FIFO
  // still accepts the captured byte in the same cycle.
  assign w_pop  = bus.rd & ~w_empty;
  assign w_push = r_cap.valid & (~w_full | w_pop);
  assign w_drop = r_cap.valid & ~w_push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_prev    <= 1'b0;
      r_cap        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_prev  <= bus.rxReady;
      r_cap.valid <= w_wr_evt & ~bus.rxError;
      if (w_wr_evt) begin
        r_cap.data <= bus.rxData;
      end

      r_data_valid <= w_pop;
      if (w_pop) begin
        r_data <= w_pop_data;
      end

      // A setting event in the same cycle as clrFlags keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clrFlags) begin
        r_overflow <= 1'b0;
      end

      if (w_bad_byte) begin
        r_frame_err <= 1'b1;
      end else if (bus.clrFlags) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_cap.data),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (w_count)
  );

  assign bus.data      = r_data;
  assign bus.dataValid = r_data_valid;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;
  assign bus.frameErr  = r_frame_err;
endmodule
